// File: rtl/seq_run_pkg.sv
// Shared constants and the saturating-increment helper for the run detector.
package seq_run_pkg;

    localparam logic MODE_ANY    = 1'b0;
    localparam logic MODE_TARGET = 1'b1;
    localparam int   SAT_W       = 32;

    function automatic logic [SAT_W-1:0] sat_inc(
        input logic [SAT_W-1:0] value,
        input logic [SAT_W-1:0] limit
    );
        return (value >= limit) ? value : value + SAT_W'(1);
    endfunction

endpackage

// File: rtl/seq_run_sat_cnt.sv
// Saturating counter: clear on reset, load 1, increment to LIMIT, or hold.
module seq_run_sat_cnt
    import seq_run_pkg::*;
#(
    parameter int               CNT_W = 8,
    parameter logic [CNT_W-1:0] LIMIT = '1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load1,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count;
        if (load1) begin
            count_next = CNT_W'(1);
        end else if (inc) begin
            count_next = CNT_W'(sat_inc(SAT_W'(count), SAT_W'(LIMIT)));
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/seq_run_detector.sv
// Run-length detector: z when the last RUN_LEN accepted symbols match.
// Define SEQ_RUN_DET_COUNT_EN to build the detection-event counter on det_cnt.
module seq_run_detector
    import seq_run_pkg::*;
#(
    parameter int SYM_W   = 1,
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             en,
    input  logic [SYM_W-1:0] w,
    input  logic             mode,
    input  logic [SYM_W-1:0] target,
    output logic             z,
    output logic [CNT_W-1:0] run_len_o,
    output logic [SYM_W-1:0] last_sym,
    output logic [CNT_W-1:0] det_cnt
);

    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(RUN_LEN);

    logic             have_sym;
    logic             new_sym;
    logic [CNT_W-1:0] run;

    assign new_sym = !have_sym || (w != last_sym);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            have_sym <= 1'b0;
            last_sym <= '0;
        end else if (en) begin
            have_sym <= 1'b1;
            last_sym <= w;
        end
    end

    seq_run_sat_cnt #(
        .CNT_W (CNT_W),
        .LIMIT (RUN_MAX)
    ) u_run (
        .clock  (clock),
        .resetn (resetn),
        .load1  (en && new_sym),
        .inc    (en && !new_sym),
        .count  (run)
    );

    assign run_len_o = run;
    assign z = (run == RUN_MAX) &&
               ((mode == MODE_ANY) || (last_sym == target));

`ifdef SEQ_RUN_DET_COUNT_EN
    localparam logic [CNT_W-1:0] RUN_PRE = CNT_W'(RUN_LEN - 1);

    logic             full_next;
    logic             z_next;
    logic             z_seen;
    logic [SYM_W-1:0] sym_next;

    // A load gives run=1, never full, since RUN_LEN is at least 2.
    assign full_next = en ? (!new_sym && (run >= RUN_PRE))
                          : (run == RUN_MAX);
    assign sym_next  = en ? w : last_sym;
    assign z_next    = full_next &&
                       ((mode == MODE_ANY) || (sym_next == target));

    always_ff @(posedge clock) begin
        if (!resetn) begin
            z_seen <= 1'b0;
        end else begin
            z_seen <= z_next;
        end
    end

    seq_run_sat_cnt #(
        .CNT_W (CNT_W),
        .LIMIT ('1)
    ) u_det (
        .clock  (clock),
        .resetn (resetn),
        .load1  (1'b0),
        .inc    (z_next && !z_seen),
        .count  (det_cnt)
    );
`else
    assign det_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_run_detector.sv
// Randomised bench for seq_run_detector against a history-queue model.
module tb_seq_run_detector;

    localparam int RL_A = 4;
    localparam int RL_B = 3;
`ifdef SEQ_RUN_DET_COUNT_EN
    localparam int DET_EXP = 2;
`else
    localparam int DET_EXP = 0;
`endif

    logic       clock  = 1'b0;
    logic       resetn = 1'b0;
    logic       en     = 1'b0;
    logic       wa     = 1'b0;
    logic       mode_a = 1'b0;
    logic       ta     = 1'b0;
    logic [2:0] wb     = 3'd0;
    logic       mode_b = 1'b0;
    logic [2:0] tgt_b  = 3'd0;

    logic       za, zb;
    logic       la;
    logic [2:0] lb;
    logic [7:0] run_a, run_b, det_a, det_b;

    always #5 clock = ~clock;

    seq_run_detector #(.SYM_W(1), .RUN_LEN(RL_A), .CNT_W(8)) u_a (
        .clock     (clock),
        .resetn    (resetn),
        .en        (en),
        .w         (wa),
        .mode      (mode_a),
        .target    (ta),
        .z         (za),
        .run_len_o (run_a),
        .last_sym  (la),
        .det_cnt   (det_a)
    );

    seq_run_detector #(.SYM_W(3), .RUN_LEN(RL_B), .CNT_W(8)) u_b (
        .clock     (clock),
        .resetn    (resetn),
        .en        (en),
        .w         (wb),
        .mode      (mode_b),
        .target    (tgt_b),
        .z         (zb),
        .run_len_o (run_b),
        .last_sym  (lb),
        .det_cnt   (det_b)
    );

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Model: accepted symbols since reset; run = trailing equal count, capped.
    int ha[$];
    int hb[$];
    int det_ma = 0;
    int det_mb = 0;
    bit pz_a = 1'b0;
    bit pz_b = 1'b0;
    bit zn_a, zn_b;
    bit started = 1'b0;

    function automatic int trail(input int q[$], input int lim);
        int n = 0;
        int k = q.size();
        while (n < k && n < lim && q[k-1-n] == q[k-1]) n++;
        return n;
    endfunction

    function automatic int lastof(input int q[$]);
        return (q.size() == 0) ? 0 : q[q.size()-1];
    endfunction

    function automatic bit zof(input int q[$], input int lim,
                               input bit m, input int t);
        return (trail(q, lim) == lim) && (!m || lastof(q) == t);
    endfunction

    always @(posedge clock) begin
        if (!resetn) begin
            ha.delete();
            hb.delete();
            det_ma  = 0;
            det_mb  = 0;
            pz_a    = 1'b0;
            pz_b    = 1'b0;
            started = 1'b1;
        end else begin
            if (en) begin
                ha.push_back(int'(wa));
                hb.push_back(int'(wb));
                if (ha.size() > 64) void'(ha.pop_front());
                if (hb.size() > 64) void'(hb.pop_front());
            end
`ifdef SEQ_RUN_DET_COUNT_EN
            zn_a = zof(ha, RL_A, mode_a, int'(ta));
            zn_b = zof(hb, RL_B, mode_b, int'(tgt_b));
            if (zn_a && !pz_a && det_ma < 255) det_ma++;
            if (zn_b && !pz_b && det_mb < 255) det_mb++;
            pz_a = zn_a;
            pz_b = zn_b;
`endif
        end
    end

    always @(negedge clock) begin
        if (started) begin
            chk("z_a",    32'(za),    32'(zof(ha, RL_A, mode_a, int'(ta))));
            chk("run_a",  32'(run_a), 32'(trail(ha, RL_A)));
            chk("last_a", 32'(la),    32'(lastof(ha)));
            chk("det_a",  32'(det_a), 32'(det_ma));
            chk("z_b",    32'(zb),    32'(zof(hb, RL_B, mode_b, int'(tgt_b))));
            chk("run_b",  32'(run_b), 32'(trail(hb, RL_B)));
            chk("last_b", 32'(lb),    32'(lastof(hb)));
            chk("det_b",  32'(det_b), 32'(det_mb));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int p3[6] = '{1, 1, 0, 1, 1, 1};
    int p6[7] = '{5, 5, 5, 5, 2, 2, 2};

    initial begin
        resetn = 1'b0;
        en     = 1'b1;
        tick();
        chk("rst_z",   32'(za),    32'd0);
        chk("rst_run", 32'(run_a), 32'd0);
        chk("rst_det", 32'(det_a), 32'd0);
        resetn = 1'b1;

        for (int i = 1; i <= 4; i++) begin
            wa = 1'b0;
            tick();
            chk("t1_run", 32'(run_a), 32'(i));
            chk("t1_z",   32'(za),    32'(i == 4));
        end

        for (int i = 1; i <= 6; i++) begin
            wa = 1'b1;
            tick();
            chk("t2_run", 32'(run_a), 32'((i < 4) ? i : 4));
            chk("t2_z",   32'(za),    32'(i >= 4));
        end
        wa = 1'b0;
        tick();
        chk("t2_brk_z",   32'(za),    32'd0);
        chk("t2_brk_run", 32'(run_a), 32'd1);

        for (int i = 0; i < 6; i++) begin
            wa = p3[i][0];
            tick();
            chk("t3_z", 32'(za), 32'd0);
        end
        chk("t3_run", 32'(run_a), 32'd3);

        wa = 1'b0;
        tick();
        tick();
        en = 1'b0;
        wa = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_hold", 32'(run_a), 32'd2);
        end
        en = 1'b1;
        wa = 1'b0;
        tick();
        chk("t4_z3", 32'(za), 32'd0);
        tick();
        chk("t4_z4", 32'(za), 32'd1);

        mode_a = 1'b1;
        ta     = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("t5_run", 32'(run_a), 32'd4);
        chk("t5_z",   32'(za),    32'd0);
        ta = 1'b0;
        #1;
        chk("t5_tgt_z", 32'(za), 32'd1);
        resetn = 1'b0;
        tick();
        chk("t5_rst_z",   32'(za),    32'd0);
        chk("t5_rst_run", 32'(run_a), 32'd0);
        resetn = 1'b1;
        mode_a = 1'b0;

        for (int i = 0; i < 7; i++) begin
            wb = p6[i][2:0];
            tick();
            if (i == 2) chk("t6_z", 32'(zb), 32'd1);
        end
        chk("t6_det", 32'(det_b), 32'(DET_EXP));

        for (int n = 0; n < 2000; n++) begin
            resetn = ($urandom_range(63) != 0);
            en     = ($urandom_range(3) != 0);
            if ($urandom_range(3) == 0) wa = ~wa;
            if ($urandom_range(2) == 0) wb = 3'($urandom_range(7));
            if ($urandom_range(15) == 0) mode_a = ~mode_a;
            if ($urandom_range(15) == 0) ta = ~ta;
            if ($urandom_range(15) == 0) mode_b = ~mode_b;
            if ($urandom_range(15) == 0) tgt_b = 3'($urandom_range(7));
            tick();
        end
        resetn = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
